// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: DEPTH-entry valid/ready buffer between two pipeline stages.
// Carries an opaque WIDTH-bit payload in strict FIFO order with at least one
// cycle of latency. It supports a flush for squash and reports occupancy.
// READY_CUT selects between a registered ready and a ready that accepts a push
// into a full buffer while it is being drained.
module pipe_stage_fifo #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 2,
    parameter int READY_CUT = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] cnt, cnt_next;
    // full/empty are kept as flops so ready and valid come straight from registers
    logic             full_q, empty_q;
    logic             push, pop;

    // Pointers wrap by explicit compare so any DEPTH works, not just powers of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready is either a pure register, or it also admits a push when the head leaves
    generate
        if (READY_CUT != 0) begin : g_cut
            assign in_ready_o = !full_q;
        end else begin : g_pass
            assign in_ready_o = !full_q | out_ready_i;
        end
    endgenerate

    assign out_valid_o = !empty_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign count_o     = cnt;

    // Next occupancy; a simultaneous push and pop cancel out
    always_comb begin
        cnt_next = cnt + CNT_W'(push) - CNT_W'(pop);
    end

    // The head is masked while empty so the output never shows stale storage
    always_comb begin
        out_data_o = '0;
        if (out_valid_o) out_data_o = storage[rd_ptr];
    end

    // Control state: reset beats flush, and flush beats any push or pop
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            cnt     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt     <= cnt_next;
            full_q  <= (cnt_next == FULL_CNT);
            empty_q <= (cnt_next == '0);
        end
    end

    // Payload storage is not reset. A write during flush or reset is dropped,
    // because the pointers are cleared in that same cycle.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) storage[wr_ptr] <= in_data_i;
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo. It uses three instances: DEPTH=2/READY_CUT=1,
// DEPTH=2/READY_CUT=0 and DEPTH=3/READY_CUT=1. Each vector sets the inputs for one
// cycle. It compares the outputs seen before the clock edge, which show the state
// left by earlier vectors plus the current inputs. The bench then advances one cycle.
module tb_pipe_stage_fifo;
    localparam int W = 8;
    localparam int DEP [3] = '{2, 2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst [3], flush [3], vld [3], rdy [3], ordy [3], ovld [3];
    logic [W-1:0] din [3], dout [3];
    logic [1:0]   cnt [3];

    int checks   = 0;
    int failures = 0;

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(2), .READY_CUT(1)) u_d2c1 (
        .clk_i(clk), .rst_i(rst[0]), .flush_i(flush[0]),
        .in_valid_i(vld[0]), .in_ready_o(ordy[0]), .in_data_i(din[0]),
        .out_valid_o(ovld[0]), .out_ready_i(rdy[0]), .out_data_o(dout[0]),
        .count_o(cnt[0]));

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(2), .READY_CUT(0)) u_d2c0 (
        .clk_i(clk), .rst_i(rst[1]), .flush_i(flush[1]),
        .in_valid_i(vld[1]), .in_ready_o(ordy[1]), .in_data_i(din[1]),
        .out_valid_o(ovld[1]), .out_ready_i(rdy[1]), .out_data_o(dout[1]),
        .count_o(cnt[1]));

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(3), .READY_CUT(1)) u_d3c1 (
        .clk_i(clk), .rst_i(rst[2]), .flush_i(flush[2]),
        .in_valid_i(vld[2]), .in_ready_o(ordy[2]), .in_data_i(din[2]),
        .out_valid_o(ovld[2]), .out_ready_i(rdy[2]), .out_data_o(dout[2]),
        .count_o(cnt[2]));

    typedef struct {
        string        nm;
        int           d;
        logic         r, f, v;
        logic [W-1:0] x;
        logic         o;
        logic         ev;
        logic [W-1:0] ed;
        logic [1:0]   ec;
        logic         er;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input string nm, input int d, input logic r, input logic f,
                       input logic v, input logic [W-1:0] x, input logic o,
                       input logic ev, input logic [W-1:0] ed, input logic [1:0] ec,
                       input logic er);
        vec_t t;
        t.nm = nm; t.d = d; t.r = r; t.f = f; t.v = v; t.x = x; t.o = o;
        t.ev = ev; t.ed = ed; t.ec = ec; t.er = er;
        tbl.push_back(t);
    endtask

    // Drive one cycle on instance d (others idle), compare, then clock
    task automatic run(input string nm, input int d, input logic r, input logic f,
                       input logic v, input logic [W-1:0] x, input logic o,
                       input logic ev, input logic [W-1:0] ed, input logic [1:0] ec,
                       input logic er);
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0; flush[i] = 1'b0; vld[i] = 1'b0; rdy[i] = 1'b0;
        end
        rst[d] = r; flush[d] = f; vld[d] = v; din[d] = x; rdy[d] = o;
        #1;
        checks++;
        if (ovld[d] !== ev || dout[d] !== ed || cnt[d] !== ec || ordy[d] !== er ||
            int'(cnt[d]) > DEP[d]) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got v=%b d=%h c=%0d r=%b, want v=%b d=%h c=%0d r=%b",
                     nm, d, $time, ovld[d], dout[d], cnt[d], ordy[d], ev, ed, ec, er);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- table: fill/drain, streaming (d0); full push+pop, flush (d1)
        add("reset_state", 0, 0,0,1,8'hA1,0, 0,8'h00,0,1);
        add("fill_1",      0, 0,0,1,8'hB2,0, 1,8'hA1,1,1);
        add("full_hold",   0, 0,0,1,8'hC3,0, 1,8'hA1,2,0);
        add("full_hold2",  0, 0,0,1,8'hC3,0, 1,8'hA1,2,0);
        add("drain_a1",    0, 0,0,0,8'h00,1, 1,8'hA1,2,0);
        add("drain_b2",    0, 0,0,0,8'h00,1, 1,8'hB2,1,1);
        add("empty_zero",  0, 0,0,0,8'h00,0, 0,8'h00,0,1);
        add("stream_1",    0, 0,0,1,8'd1,1,  0,8'h00,0,1);
        for (int k = 2; k <= 10; k++)
            add("stream", 0, 0,0,1,W'(k),1, 1,W'(k-1),1,1);
        add("stream_end",  0, 0,0,0,8'h00,1, 1,8'd10,1,1);
        add("stream_idle", 0, 0,0,0,8'h00,0, 0,8'h00,0,1);

        add("rc0_reset",   1, 0,0,1,8'h11,0, 0,8'h00,0,1);
        add("rc0_fill",    1, 0,0,1,8'h22,0, 1,8'h11,1,1);
        add("rc0_full_nr", 1, 0,0,1,8'h44,0, 1,8'h11,2,0);
        add("rc0_pushpop", 1, 0,0,1,8'h33,1, 1,8'h11,2,1);
        add("rc0_out22",   1, 0,0,0,8'h00,1, 1,8'h22,2,1);
        add("rc0_out33",   1, 0,0,0,8'h00,1, 1,8'h33,1,1);
        add("rc0_empty",   1, 0,0,0,8'h00,0, 0,8'h00,0,1);
        add("fl_fill_a",   1, 0,0,1,8'hAA,0, 0,8'h00,0,1);
        add("fl_fill_b",   1, 0,0,1,8'hBB,0, 1,8'hAA,1,1);
        add("fl_collide",  1, 0,1,1,8'h77,1, 1,8'hAA,2,1);
        add("fl_after",    1, 0,0,0,8'h00,1, 0,8'h00,0,1);
        add("fl_no77",     1, 0,0,0,8'h00,0, 0,8'h00,0,1);

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; flush[i] = 1'b0; vld[i] = 1'b0; rdy[i] = 1'b0; din[i] = '0;
        end
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        foreach (tbl[i])
            run(tbl[i].nm, tbl[i].d, tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].x, tbl[i].o,
                tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].er);

        // ---- backpressure: head 0x55 held while upstream data toggles
        run("bp_push", 0, 0,0,1,8'h55,0, 0,8'h00,0,1);
        for (int i = 0; i < 5; i++)
            run("bp_hold", 0, 0,0,1, (i % 2) ? 8'hF0 : 8'h0F, 0,
                1,8'h55, (i == 0) ? 2'd1 : 2'd2, (i == 0));
        run("bp_drain55", 0, 0,0,0,8'h00,1, 1,8'h55,2,0);
        run("bp_drain0f", 0, 0,0,0,8'h00,1, 1,8'h0F,1,1);
        run("bp_empty",   0, 0,0,0,8'h00,0, 0,8'h00,0,1);

        // ---- DEPTH=3: full boundary, then flush to clear
        run("d3_fill0", 2, 0,0,1,8'h01,0, 0,8'h00,0,1);
        run("d3_fill1", 2, 0,0,1,8'h02,0, 1,8'h01,1,1);
        run("d3_fill2", 2, 0,0,1,8'h03,0, 1,8'h01,2,1);
        run("d3_full",  2, 0,0,1,8'h04,0, 1,8'h01,3,0);
        run("d3_flush", 2, 0,1,0,8'h00,0, 1,8'h01,3,0);
        run("d3_clear", 2, 0,0,0,8'h00,0, 0,8'h00,0,1);

        // ---- DEPTH=3: 7 push/pop pairs wrap the pointers twice, then reset mid-stream
        for (int k = 0; k < 8; k++)
            run("wrap", 2, 0,0,1, W'(8'h40 + k), 1,
                (k > 0), (k > 0) ? W'(8'h40 + k - 1) : 8'h00, (k > 0) ? 2'd1 : 2'd0, 1);
        run("wrap_hold", 2, 0,0,1,8'h48,0, 1,8'h47,1,1);
        run("rst_mid",   2, 1,0,1,8'hEE,1, 1,8'h47,2,1);
        run("post_rst",  2, 0,0,1,8'h99,0, 0,8'h00,0,1);
        run("first_99",  2, 0,0,0,8'h00,1, 1,8'h99,1,1);
        run("final_emp", 2, 0,0,0,8'h00,0, 0,8'h00,0,1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_fifo.md
Name: pipe_stage_fifo

Overview:
- Parametrised successor to the single-entry inter-stage register: a DEPTH-entry valid/ready pipeline buffer carrying an opaque WIDTH-bit payload (the packed stage bundle).
- Placed between any two pipeline stages (IF/ID, ID/EX, EX/MEM, ...).
- Adds a flush input for branch/trap squash, occupancy reporting, and an optional registered ready that breaks the combinational ready chain.

Parameters:
- WIDTH, 64, payload width in bits; must be >= 1.
- DEPTH, 2, number of storage entries; must be >= 1; any integer, not restricted to powers of two.
- READY_CUT, 1:
  - 1: in_ready_o = !full, a pure register output.
  - 0: in_ready_o = !full | out_ready_i, so a push is accepted into a full buffer when a pop happens in the same cycle.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- flush_i  input  1  squash all stored entries.
- in_valid_i  input  1  upstream has a payload.
- in_ready_o  output  1  buffer accepts the payload this cycle.
- in_data_i  input  WIDTH  upstream payload.
- out_valid_o  output  1  head entry is valid.
- out_ready_i  input  1  downstream consumes the head entry.
- out_data_o  output  WIDTH  head entry payload.
- count_o  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage: circular array of DEPTH entries with head pointer rd_ptr, tail pointer wr_ptr and occupancy cnt.
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare, never by natural overflow.
  - empty = (cnt == 0); full = (cnt == DEPTH).
- Handshake:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - out_valid_o = !empty.
  - in_ready_o is computed per READY_CUT. It never depends on in_valid_i.
- Latency and ordering:
  - A payload pushed in cycle N is visible on out_data_o in cycle N+1 at the earliest. There is no combinational in-to-out path.
  - Strict FIFO order.
- Output data: out_data_o = storage[rd_ptr] when out_valid_o = 1, otherwise all zeros. The output is masked, so it is deterministic while empty.
- Stability: while out_valid_o = 1 and out_ready_i = 0, out_valid_o and out_data_o hold unchanged, unless flush_i is asserted.
- Counting:
  - cnt_next = cnt + push - pop.
  - Simultaneous push and pop leaves cnt unchanged; both pointers advance.
  - With READY_CUT = 0 and full, a simultaneous push and pop is legal; the tail slot overwrites nothing because the head has advanced.
  - With DEPTH = 1, READY_CUT = 0 reproduces the single-register behaviour at full throughput. DEPTH = 1 with READY_CUT = 1 gives at most 1 transfer per 2 cycles.
- Flush:
  - When flush_i = 1 at a rising edge: cnt, rd_ptr and wr_ptr are set to 0, and any push or pop in that cycle is discarded. Flush has priority over push.
  - out_valid_o = 0 in the following cycle.
  - Storage contents are not cleared.
  - During the flush cycle itself, outputs still reflect pre-flush state. Upstream must not treat an accepted push in that cycle as delivered.
- Reset:
  - When rst_i = 1 at a rising edge: cnt, rd_ptr and wr_ptr are set to 0.
  - Outputs after reset: out_valid_o = 0, out_data_o = 0, count_o = 0, in_ready_o = 1.
  - Reset overrides flush, push and pop.
  - Reset mid-stream discards all entries; no partial payload is ever emitted afterwards.
  - Storage registers need no reset.
- count_o = cnt, registered.
- Illegal use: a push while full with READY_CUT = 1 cannot occur (in_ready_o = 0). The bench asserts that cnt never exceeds DEPTH.

Test Plan:
- Fill and drain:
  - Stimulus: DEPTH=2, READY_CUT=1, out_ready_i=0; push 0xA1, then 0xB2.
  - Required: count_o = 1, then 2; in_ready_o = 0 after the second push; a third push of 0xC3 is held off.
  - Then out_ready_i=1 → out_data_o = 0xA1, then 0xB2; count_o returns to 0; out_data_o = 0 when empty.
- Streaming:
  - Stimulus: in_valid_i and out_ready_i held at 1 for 10 cycles with incrementing data 1..10.
  - Required: after 1 cycle of latency, one transfer per cycle, outputs 1..10 in order, count_o steady at 1.
- Backpressure hold:
  - Stimulus: head = 0x55, out_ready_i=0 for 5 cycles while upstream toggles in_data_i.
  - Required: out_data_o stays 0x55 and out_valid_o stays 1 throughout.
- Full with simultaneous push and pop:
  - Stimulus: DEPTH=2, READY_CUT=0, buffer full with 0x11, 0x22; push 0x33 with out_ready_i=1.
  - Required: in_ready_o = 1, 0x11 popped, count_o stays 2, subsequent outputs are 0x22 then 0x33.
- Flush collision:
  - Stimulus: 2 entries stored; assert flush_i together with a push of 0x77 and out_ready_i=1.
  - Required: next cycle out_valid_o = 0 and count_o = 0; 0x77 never appears on the output.
- Reset mid-operation and wrap:
  - Stimulus: DEPTH=3; run 7 push/pop pairs so the pointers wrap twice, checking order; assert rst_i with 2 entries stored.
  - Required: next cycle out_valid_o = 0, count_o = 0, in_ready_o = 1, out_data_o = 0; the next push (0x99) emerges first.
